// File: rtl/sblk_row_dispatch.sv
// Row dispatcher: fans one instruction stream out to N_ROW superblock rows and routes activations
// through per-row holding registers. Define SBLK_ROW_DISPATCH_PERF_EN to build the perf counters.

module sblk_row_hold #(
    parameter int W = 32
) (
    input  logic         clk_h,
    input  logic         rst_n,
    input  logic         load,
    input  logic         drain,
    input  logic [W-1:0] din,
    output logic         vld,
    output logic [W-1:0] dat
);
    // Load wins over drain so a same-cycle drain/refill keeps vld high with the new word.
    always_ff @(posedge clk_h or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
            dat <= '0;
        end else if (load) begin
            vld <= 1'b1;
            dat <= din;
        end else if (drain) begin
            vld <= 1'b0;
        end
    end
endmodule

module sblk_row_dispatch #(
    parameter int N_ROW      = 12,
    parameter int WID_ROW    = $clog2(N_ROW),
    parameter int WID_ACT    = 16,
    parameter int WID_INST   = 14,
    parameter int SETTLE_CYC = 2
) (
    input  logic                        clk_h,
    input  logic                        rst_n,
    input  logic [WID_INST-1:0]         inst_in,
    input  logic [N_ROW-1:0]            inst_mask,
    input  logic                        inst_vld,
    output logic                        inst_rdy,
    input  logic [2*WID_ACT-1:0]        act_in,
    input  logic [WID_ROW-1:0]          act_row,
    input  logic                        act_bcast,
    input  logic                        act_vld,
    output logic                        act_rdy,
    output logic [WID_INST*N_ROW-1:0]   inst_data,
    output logic [N_ROW-1:0]            inst_en,
    output logic [2*WID_ACT*N_ROW-1:0]  act_data_in,
    output logic [N_ROW-1:0]            act_data_in_vld,
    input  logic [N_ROW-1:0]            act_data_in_req,
    input  logic [N_ROW-1:0]            status_sblk,
    output logic                        busy,
    output logic                        err_bad_row,
    output logic [31:0]                 perf_inst_cnt,
    output logic [31:0]                 perf_act_stall
);
    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, WAIT} state_t;

    state_t                                 state;
    logic [CW-1:0]                          settle_cnt;
    logic [N_ROW-1:0]                       mask_q;
    logic [WID_INST-1:0]                    inst_q;
    logic [N_ROW-1:0]                       tgt;
    logic [N_ROW-1:0]                       row_ok;
    logic [N_ROW-1:0]                       hold_vld;
    logic [N_ROW-1:0][2*WID_ACT-1:0]        hold_dat;
    logic                                   row_bad;
    logic                                   act_acc;

    // Gating with rst_n keeps the handshake outputs at 0 while reset is held.
    assign inst_rdy = (state == IDLE) & rst_n;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk_h or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            mask_q     <= '0;
            inst_q     <= '0;
            inst_en    <= '0;
        end else begin
            inst_en <= '0;
            case (state)
                IDLE: if (inst_vld && inst_mask != '0) begin
                    inst_q  <= inst_in;
                    mask_q  <= inst_mask;
                    inst_en <= inst_mask;
                    state   <= ISSUE;
                end
                ISSUE: begin
                    settle_cnt <= CW'(SETTLE_CYC - 1);
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == '0) state <= WAIT;
                    else                  settle_cnt <= settle_cnt - 1'b1;
                end
                WAIT: if ((status_sblk & mask_q) == '0) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        inst_data = '0;
        for (int r = 0; r < N_ROW; r++) inst_data[r*WID_INST +: WID_INST] = inst_q;
    end

    // Unicast to a non-existent row yields an empty target set: accepted and dropped.
    assign row_bad = !act_bcast && (32'(act_row) >= 32'(N_ROW));
    assign tgt     = act_bcast ? {N_ROW{1'b1}} :
                     row_bad   ? '0 : ({{(N_ROW-1){1'b0}}, 1'b1} << act_row);
    assign row_ok  = ~tgt | ~hold_vld | act_data_in_req;
    assign act_rdy = (&row_ok) & rst_n;
    assign act_acc = act_vld & act_rdy;

    genvar g;
    generate
        for (g = 0; g < N_ROW; g++) begin : g_row
            sblk_row_hold #(.W(2*WID_ACT)) u_hold (
                .clk_h (clk_h),
                .rst_n (rst_n),
                .load  (act_acc & tgt[g]),
                .drain (act_data_in_req[g]),
                .din   (act_in),
                .vld   (hold_vld[g]),
                .dat   (hold_dat[g])
            );
        end
    endgenerate

    assign act_data_in_vld = hold_vld;
    assign act_data_in     = hold_dat;

    always_ff @(posedge clk_h or negedge rst_n) begin
        if (!rst_n) err_bad_row <= 1'b0;
        else        err_bad_row <= act_vld & row_bad;
    end

`ifdef SBLK_ROW_DISPATCH_PERF_EN
    logic inst_acc;
    assign inst_acc = inst_vld & inst_rdy & (|inst_mask);

    always_ff @(posedge clk_h or negedge rst_n) begin
        if (!rst_n) begin
            perf_inst_cnt  <= '0;
            perf_act_stall <= '0;
        end else begin
            if (inst_acc && perf_inst_cnt != '1)            perf_inst_cnt  <= perf_inst_cnt + 1'b1;
            if (act_vld && !act_rdy && perf_act_stall != '1) perf_act_stall <= perf_act_stall + 1'b1;
        end
    end
`else
    assign perf_inst_cnt  = '0;
    assign perf_act_stall = '0;
`endif

endmodule

// File: doc/sblk_row_dispatch.md
Name: sblk_row_dispatch

Overview:
- Single-clock front-end that feeds a row of N_ROW superblocks from one instruction stream and one activation stream.
- Instruction path: each instruction carries a row mask. The block fans it out as one-cycle inst_en pulses, then waits for the masked rows to go idle before accepting the next one.
- Activation path: unicast or broadcast to rows through per-row holding registers with a vld/req handshake.
- Replaces per-row external driving of inst_en/act_data_in and adds a broadcast mode plus busy tracking.

Parameters:
N_ROW, 12, number of superblock rows
WID_ROW, $clog2(N_ROW), row index width
WID_ACT, 16, activation half-word width (row payload is 2*WID_ACT)
WID_INST, 14, instruction word width (TN 3 + TM 3 + TP 2 + LN 3 + LP 3)
SETTLE_CYC, 2, cycles after issue during which status_sblk is ignored (min 1)

Ports:
clk_h  in  1  clock
rst_n  in  1  asynchronous active-low reset
inst_in  in  WID_INST  instruction word
inst_mask  in  N_ROW  target rows of inst_in
inst_vld  in  1  instruction valid
inst_rdy  out  1  instruction ready
act_in  in  2*WID_ACT  activation payload
act_row  in  WID_ROW  destination row (unicast)
act_bcast  in  1  1 = write to all rows, act_row ignored
act_vld  in  1  activation valid
act_rdy  out  1  activation ready
inst_data  out  WID_INST*N_ROW  per-row instruction bus
inst_en  out  N_ROW  per-row instruction strobe
act_data_in  out  2*WID_ACT*N_ROW  per-row activation
act_data_in_vld  out  N_ROW  per-row activation valid
act_data_in_req  in  N_ROW  per-row activation request (consumer ready)
status_sblk  in  N_ROW  per-row busy (1 = busy)
busy  out  1  instruction FSM not IDLE
err_bad_row  out  1  one-cycle pulse: unicast act_row >= N_ROW dropped
perf_inst_cnt  out  32  issued instruction count
perf_act_stall  out  32  activation stall cycles

Behaviour:
- Reset: all outputs and all state = 0. Reset mid-operation drops the in-flight instruction and all held activations; no inst_en pulse follows reset.
- Instruction FSM states: IDLE, ISSUE, SETTLE, WAIT.
  - inst_rdy = (state==IDLE); busy = !inst_rdy.
  - IDLE: on inst_vld & inst_rdy with inst_mask != 0, register inst_in and inst_mask, go to ISSUE.
  - IDLE with inst_mask == 0: accept as a no-op and stay in IDLE; perf_inst_cnt is not incremented.
  - ISSUE (1 cycle): inst_en = registered mask; go to SETTLE with settle counter = SETTLE_CYC-1.
  - SETTLE: decrement the counter; at 0 go to WAIT. status_sblk is ignored here.
  - WAIT: when (status_sblk & mask) == 0, go to IDLE next cycle. Unmasked rows are never checked.
- Issue latency: inst_en is high exactly at T+1 for an accept at T. Minimum accept-to-accept spacing = SETTLE_CYC+3 cycles.
- inst_data: every N_ROW slice carries the registered instruction, stable from ISSUE until the next accept.
- Activation path: one holding register (hold_vld[r], hold_dat[r]) per row.
  - act_data_in_vld[r] = hold_vld[r]; the act_data_in slice r = hold_dat[r].
  - Transfer to row r on hold_vld[r] & act_data_in_req[r].
- Target set: tgt = act_bcast ? all ones : onehot(act_row). If act_row >= N_ROW and unicast, tgt = 0.
- act_rdy (combinational) = AND over r in tgt of (!hold_vld[r] | act_data_in_req[r]). Broadcast therefore waits until every row can take data; there are no partial writes.
- On act_vld & act_rdy: every r in tgt gets hold_dat[r] <= act_in and hold_vld[r] <= 1. Simultaneous drain and refill keeps hold_vld at 1 with the new data.
- Rows not in tgt clear hold_vld on drain.
- Unicast with act_row >= N_ROW: act_rdy = 1, the word is dropped, err_bad_row = 1 in the following cycle.
- Instruction and activation paths are independent; both may accept in the same cycle.

Optional Feature:
- SBLK_ROW_DISPATCH_PERF_EN defined:
  - perf_inst_cnt increments on each accepted instruction with nonzero mask.
  - perf_act_stall increments each cycle act_vld & !act_rdy.
  - Both saturate at 2^32-1 and reset to 0.
- Macro undefined: both ports remain and are tied to 0; no counter logic is synthesised.

Test Plan:
- Instruction issue/settle: inst_in=0x1A5, mask=0x005 accepted at T, status_sblk[0]/[2] held 1 for 6 cycles from T+2.
  - Required: inst_en=0x005 only at T+1; all slices = 0x1A5; inst_rdy returns to 1 at T+9; no inst_en otherwise.
  - Same with status always 0: next accept possible at T+5.
- Mask edge cases: mask=0x000 -> accepted, no inst_en, busy stays 0. status_sblk[7]=1 with mask=0x001 -> FSM returns to IDLE unaffected by row 7.
- Unicast backpressure: act_row=3 with act_data_in_req[3]=0 -> first word held (vld[3]=1), second word act_rdy=0. Raise req[3] -> drain and refill in the same cycle, vld[3] stays 1 with the second word.
- Broadcast: act_bcast=1, act_in=0xBEEF_0001, all req=1 except row 11 held with vld[11]=1 -> act_rdy=0. Release row 11 -> all 12 slices = 0xBEEF0001 on the same cycle.
- Bad row: act_row=13, N_ROW=12 -> act_rdy=1, no vld change, err_bad_row high exactly one cycle.
- Reset: assert rst_n=0 during SETTLE with held activations -> all outputs 0 asynchronously. After release, inst_rdy=1 and no inst_en. With PERF_EN, counters read 0; after 3 issues and 4 stall cycles they read 3 and 4.
